stg_ma_mp: RTL
==============

Name: stg_ma_mp

Overview:
Parametrised memory-access pipeline stage with N memory ports, placed between execute and write-back.
- Registers the instruction bundle (pc, instr, opc, GP/SR targets, result).
- For load/store ops, issues a request on one of N_PORTS memory ports and holds it until acknowledged or timed out.
- Port selection is round-robin or address-interleaved.
- Valid/ready handshakes on both sides allow stalls upstream and downstream.

Parameters:
N_PORTS, 2, number of memory ports; power of two, >=2
MP_MODE, 0, 0 = round-robin port select, 1 = address-interleaved (port = addr[MP_W-1:0])
ADDR_W, 24, address width
DATA_W, 24, data width
OPC_W, 8, opcode width
TGT_GP_W, 4, GP target index width
TGT_SR_W, 2, SR target index width
TIMEOUT, 15, max request cycles before abort; >=1
(MP_W = $clog2(N_PORTS), derived localparam)

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset, asynchronous, active-high
iw_valid  in  1  upstream bundle valid
ow_ready  out  1  stage can accept
iw_pc/iw_instr/iw_opc  in  ADDR_W/DATA_W/OPC_W  bundle fields
iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we  in  TGT_GP_W,1,TGT_SR_W,1  write targets
iw_mem_rd, iw_mem_wr  in  1,1  decoded load/store; both high is illegal (treated as store)
iw_addr  in  ADDR_W  effective address
iw_result  in  DATA_W  ALU result / store data
ow_valid  out  1  output bundle valid
iw_ready  in  1  downstream accepts
ow_pc/ow_instr/ow_opc/ow_tgt_gp/ow_tgt_gp_we/ow_tgt_sr/ow_tgt_sr_we  out  as inputs  registered bundle
ow_result  out  DATA_W  load data, or passed-through result
ow_fault  out  1  memory op timed out
ow_mem_req  out  N_PORTS  one-hot request
ow_mem_we  out  1  write enable for active request
ow_mem_addr  out  ADDR_W  request address
ow_mem_wdata  out  DATA_W  store data
iw_mem_ack  in  N_PORTS  per-port acknowledge
iw_mem_rdata  in  N_PORTS*DATA_W  per-port read data; port p at [p*DATA_W +: DATA_W]
ow_mem_mp  out  MP_W  port index of current/last memory op

Behaviour:
- Reset (async): all outputs 0, state S_IDLE, round-robin pointer 0, timeout counter 0. Reset mid-request drops ow_mem_req immediately; no completion is produced.
- States: S_IDLE, S_REQ.
- ow_ready = (state==S_IDLE) && (!ow_valid || iw_ready). Accept = iw_valid && ow_ready.
- Downstream: ow_valid clears on iw_ready unless a new bundle completes on the same edge.
- Non-memory accept: fields latched, ow_result = iw_result, ow_fault = 0, ow_valid = 1 next cycle. Latency 1; back-to-back throughput 1/cycle.
- Memory accept:
  - Fields, addr and wdata are latched; ow_valid = 0; state -> S_REQ.
  - Port is selected: MP_MODE 0 uses the pointer, which then advances mod N_PORTS (wraps N-1 -> 0). MP_MODE 1 uses addr[MP_W-1:0].
  - ow_mem_mp is updated on the same edge.
  - Non-memory ops never advance the pointer.
- S_REQ:
  - ow_mem_req = one-hot(ow_mem_mp); ow_mem_we = stored store-flag; addr and wdata stable until exit.
  - Timeout counter increments each S_REQ cycle.
  - Only iw_mem_ack[ow_mem_mp] is honoured; acks on other ports, and acks while in S_IDLE, are ignored.
- Ack edge:
  - Load: ow_result = rdata slice of the selected port. Store: ow_result = store data.
  - ow_fault = 0, ow_valid = 1, state -> S_IDLE, req drops next cycle.
  - Minimum memory-op latency is 2 edges (accept, ack in first S_REQ cycle).
- Timeout: on the edge where the counter reaches TIMEOUT without ack, ow_result = 0, ow_fault = 1, ow_valid = 1, state -> S_IDLE. If ack and timeout coincide, ack wins and fault = 0.
- Output register is always empty during S_REQ, so no overwrite hazard exists. No new accept occurs in S_REQ.

Test Plan:
- Reset, then 3 consecutive non-memory ops (pc 0x10, 0x11, 0x12), iw_ready = 1 -> ow_valid from cycle 1, one bundle per cycle, ow_mem_req = 0 throughout.
- MP_MODE 0, N_PORTS = 4, 5 loads, each acked after 1 cycle -> ow_mem_mp sequence 0, 1, 2, 3, 0; ow_result = rdata of that port (e.g. 0xA00000+p).
- MP_MODE 1, N_PORTS = 2, stores to 0x100 and 0x101 -> req 2'b01 then 2'b10; we = 1; wdata = iw_result; ow_result passes the store data.
- Load with no ack, TIMEOUT = 15 -> req held 15 cycles, then ow_valid = 1, ow_fault = 1, ow_result = 0; a stray ack on an unselected port during the wait is ignored.
- Downstream stall: iw_ready = 0 for 4 cycles with a bundle in output -> ow_ready = 0, outputs held stable; the next bundle is accepted on the cycle iw_ready = 1.
- Assert iw_rst while in S_REQ -> ow_mem_req = 0 immediately, ow_valid = 0, pointer = 0; a subsequent load uses port 0.

Source files
------------

// File: rtl/stg_ma_mp.sv
// Memory-access pipeline stage between execute and write-back.
// Registers the instruction bundle; load/store ops issue one request on one of
// N_PORTS memory ports (round-robin or address-interleaved) and hold it until
// the selected port acknowledges or the request times out.
module stg_ma_mp #(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned MP_MODE  = 0,
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned OPC_W    = 8,
    parameter int unsigned TGT_GP_W = 4,
    parameter int unsigned TGT_SR_W = 2,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                          iw_clk,
    input  logic                          iw_rst,
    input  logic                          iw_valid,
    output logic                          ow_ready,
    input  logic [ADDR_W-1:0]             iw_pc,
    input  logic [DATA_W-1:0]             iw_instr,
    input  logic [OPC_W-1:0]              iw_opc,
    input  logic [TGT_GP_W-1:0]           iw_tgt_gp,
    input  logic                          iw_tgt_gp_we,
    input  logic [TGT_SR_W-1:0]           iw_tgt_sr,
    input  logic                          iw_tgt_sr_we,
    input  logic                          iw_mem_rd,
    input  logic                          iw_mem_wr,
    input  logic [ADDR_W-1:0]             iw_addr,
    input  logic [DATA_W-1:0]             iw_result,
    output logic                          ow_valid,
    input  logic                          iw_ready,
    output logic [ADDR_W-1:0]             ow_pc,
    output logic [DATA_W-1:0]             ow_instr,
    output logic [OPC_W-1:0]              ow_opc,
    output logic [TGT_GP_W-1:0]           ow_tgt_gp,
    output logic                          ow_tgt_gp_we,
    output logic [TGT_SR_W-1:0]           ow_tgt_sr,
    output logic                          ow_tgt_sr_we,
    output logic [DATA_W-1:0]             ow_result,
    output logic                          ow_fault,
    output logic [N_PORTS-1:0]            ow_mem_req,
    output logic                          ow_mem_we,
    output logic [ADDR_W-1:0]             ow_mem_addr,
    output logic [DATA_W-1:0]             ow_mem_wdata,
    input  logic [N_PORTS-1:0]            iw_mem_ack,
    input  logic [N_PORTS*DATA_W-1:0]     iw_mem_rdata,
    output logic [$clog2(N_PORTS)-1:0]    ow_mem_mp
);

    localparam int unsigned MP_W  = $clog2(N_PORTS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [MP_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [TGT_GP_W-1:0] gp_q, gp_d;
    logic                gp_we_q, gp_we_d;
    logic [TGT_SR_W-1:0] sr_q, sr_d;
    logic                sr_we_q, sr_we_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                fault_q, fault_d;
    logic [N_PORTS-1:0]  req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MP_W-1:0]     mp_q, mp_d;

    logic                ready_c;
    logic                accept_c;
    logic                is_mem_c;
    logic [MP_W-1:0]     sel_c;
    logic                ack_hit_c;
    logic                timeout_hit_c;
    logic [DATA_W-1:0]   rdata_sel_c;

    // Port choice, selected-port ack and read-data mux
    always_comb begin
        ready_c       = (state_q == S_IDLE) && (!valid_q || iw_ready);
        accept_c      = iw_valid && ready_c;
        is_mem_c      = iw_mem_rd || iw_mem_wr;
        sel_c         = (MP_MODE == 0) ? ptr_q : iw_addr[MP_W-1:0];
        ack_hit_c     = iw_mem_ack[mp_q];
        timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
        rdata_sel_c   = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (mp_q == MP_W'(p)) begin
                rdata_sel_c = iw_mem_rdata[p*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: accept, request hold, ack / timeout completion
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        opc_d    = opc_q;
        gp_d     = gp_q;
        gp_we_d  = gp_we_q;
        sr_d     = sr_q;
        sr_we_d  = sr_we_q;
        result_d = result_q;
        fault_d  = fault_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mp_d     = mp_q;

        if (valid_q && iw_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    pc_d    = iw_pc;
                    instr_d = iw_instr;
                    opc_d   = iw_opc;
                    gp_d    = iw_tgt_gp;
                    gp_we_d = iw_tgt_gp_we;
                    sr_d    = iw_tgt_sr;
                    sr_we_d = iw_tgt_sr_we;
                    if (is_mem_c) begin
                        state_d = S_REQ;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        we_d    = iw_mem_wr;
                        addr_d  = iw_addr;
                        wdata_d = iw_result;
                        mp_d    = sel_c;
                        for (int unsigned p = 0; p < N_PORTS; p++) begin
                            req_d[p] = (sel_c == MP_W'(p));
                        end
                        if (MP_MODE == 0) begin
                            ptr_d = ptr_q + MP_W'(1);
                        end
                    end else begin
                        result_d = iw_result;
                        fault_d  = 1'b0;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (ack_hit_c) begin
                    result_d = we_q ? wdata_q : rdata_sel_c;
                    fault_d  = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                    req_d    = '0;
                    we_d     = 1'b0;
                    cnt_d    = '0;
                end else if (timeout_hit_c) begin
                    result_d = '0;
                    fault_d  = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                    req_d    = '0;
                    we_d     = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight request
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            gp_q     <= '0;
            gp_we_q  <= 1'b0;
            sr_q     <= '0;
            sr_we_q  <= 1'b0;
            result_q <= '0;
            fault_q  <= 1'b0;
            req_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mp_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            gp_q     <= gp_d;
            gp_we_q  <= gp_we_d;
            sr_q     <= sr_d;
            sr_we_q  <= sr_we_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mp_q     <= mp_d;
        end
    end

    assign ow_ready     = ready_c;
    assign ow_valid     = valid_q;
    assign ow_pc        = pc_q;
    assign ow_instr     = instr_q;
    assign ow_opc       = opc_q;
    assign ow_tgt_gp    = gp_q;
    assign ow_tgt_gp_we = gp_we_q;
    assign ow_tgt_sr    = sr_q;
    assign ow_tgt_sr_we = sr_we_q;
    assign ow_result    = result_q;
    assign ow_fault     = fault_q;
    assign ow_mem_req   = req_q;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_mem_mp    = mp_q;

endmodule
